// File: rtl/mole_game_pkg.sv
// Shared state encodings and output widths for the mole game; the downstream
// LED stage imports this package too, so keep encodings stable.
package mole_game_pkg;

  localparam int STATE_W = 3;
  localparam int SCORE_W = 8;
  localparam int LIVES_W = 2;
  localparam int TIME_W  = 7;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_PLAY  = 3'd2,
    ST_OVER  = 3'd3,
    ST_PAUSE = 3'd4,
    ST_CLEAR = 3'd5
  } game_state_e;

  // Score increment that sticks at the all-ones ceiling instead of wrapping.
  function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/game_down_counter.sv
// Loadable down-counter behind time_left; load wins over decrement, 1-cycle latency,
// no backpressure. zero_o: a tick now, at count 1, would land the count on zero.
module game_down_counter
  import mole_game_pkg::*;
#(
  parameter int W = TIME_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  input  logic         dec_en_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && dec_en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // Independent of dec_en_i so the FSM can consume it without a combinational loop.
  assign zero_o  = tick_i && (count_q == W'(1));

endmodule

// File: rtl/game_state_fsm.sv
// Whack-a-mole game controller; all outputs registered (1-cycle latency), no backpressure.
// Optional pause/resume state is built only when GAME_PAUSE_EN is defined.
module game_state_fsm
  import mole_game_pkg::*;
#(
  parameter int READY_TICKS = 3,
  parameter int GAME_TICKS  = 60,
  parameter int WIN_SCORE   = 20,
  parameter int LIVES_INIT  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               tick,
  input  logic               hit,
  input  logic               miss,
  output logic [STATE_W-1:0] state,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic [TIME_W-1:0]  time_left,
  output logic               mole_en
);

  localparam logic [TIME_W-1:0]  READY_LD = TIME_W'(READY_TICKS);
  localparam logic [TIME_W-1:0]  GAME_LD  = TIME_W'(GAME_TICKS);
  localparam logic [SCORE_W-1:0] WIN_LD   = SCORE_W'(WIN_SCORE);
  localparam logic [LIVES_W-1:0] LIVES_LD = LIVES_W'(LIVES_INIT);

  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               mole_en_q;

  logic              tl_load;
  logic [TIME_W-1:0] tl_load_val;
  logic              tl_dec_en;
  logic              tl_zero;
  logic [TIME_W-1:0] tl_count;

  game_down_counter #(
    .W (TIME_W)
  ) u_time_left (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tl_load),
    .load_val_i (tl_load_val),
    .tick_i     (tick),
    .dec_en_i   (tl_dec_en),
    .count_o    (tl_count),
    .zero_o     (tl_zero)
  );

`ifdef GAME_PAUSE_EN
  logic pause_req;
  assign pause_req = pause;
`else
  logic pause_req;
  logic unused_pause;
  assign pause_req    = 1'b0;
  assign unused_pause = pause;
`endif

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    lives_d     = lives_q;
    tl_load     = 1'b0;
    tl_load_val = '0;
    tl_dec_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_READY;
          score_d     = '0;
          lives_d     = LIVES_LD;
          tl_load     = 1'b1;
          tl_load_val = READY_LD;
        end
      end

      ST_READY: begin
        tl_dec_en = 1'b1;
        if (tl_zero) begin
          state_d     = ST_PLAY;
          tl_load     = 1'b1;
          tl_load_val = GAME_LD;
        end
      end

      ST_PLAY: begin
        tl_dec_en = 1'b1;
        if (hit) begin
          score_d = score_sat_inc(score_q);
        end
        if (miss && (lives_q != '0)) begin
          lives_d = lives_q - 1'b1;
        end
        // A winning hit beats a simultaneous last miss or time-out.
        if (hit && (score_d == WIN_LD)) begin
          state_d = ST_CLEAR;
        end else if ((miss && (lives_q == LIVES_W'(1))) || tl_zero) begin
          state_d = ST_OVER;
        end else if (pause_req) begin
          state_d = ST_PAUSE;
        end
      end

`ifdef GAME_PAUSE_EN
      ST_PAUSE: begin
        if (pause_req) begin
          state_d = ST_PLAY;
        end
      end
`endif

      ST_OVER, ST_CLEAR: begin
        if (start) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      score_q   <= '0;
      lives_q   <= '0;
      mole_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      mole_en_q <= (state_d == ST_PLAY);
    end
  end

  assign state     = state_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign time_left = tl_count;
  assign mole_en   = mole_en_q;

endmodule

// File: tb/tb_game_state_fsm.sv
// Directed scenarios plus randomized play checked against an integer game model.
module tb_game_state_fsm;

  localparam int RT = 3;
  localparam int GT = 60;
  localparam int WS = 20;
  localparam int LI = 3;

  localparam int S_IDLE  = 0;
  localparam int S_READY = 1;
  localparam int S_PLAY  = 2;
  localparam int S_OVER  = 3;
  localparam int S_PAUSE = 4;
  localparam int S_CLEAR = 5;

`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start, pause, tick, hit, miss;
  logic [2:0] state;
  logic [7:0] score;
  logic [1:0] lives;
  logic [6:0] time_left;
  logic       mole_en;

  int checks = 0;
  int passes = 0;

  int m_state, m_score, m_lives, m_tl;

  game_state_fsm #(
    .READY_TICKS (RT),
    .GAME_TICKS  (GT),
    .WIN_SCORE   (WS),
    .LIVES_INIT  (LI)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .tick      (tick),
    .hit       (hit),
    .miss      (miss),
    .state     (state),
    .score     (score),
    .lives     (lives),
    .time_left (time_left),
    .mole_en   (mole_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [20:0] outs();
    return {state, score, lives, time_left, mole_en};
  endfunction

  function automatic logic [20:0] pack(int st, int sc, int lv, int tl, int me);
    return {st[2:0], sc[7:0], lv[1:0], tl[6:0], me[0]};
  endfunction

  function automatic string fmt(logic [20:0] v);
    return $sformatf("st=%0d sc=%0d lv=%0d tl=%0d me=%0d",
                     v[20:18], v[17:10], v[9:8], v[7:1], v[0]);
  endfunction

  function automatic logic [20:0] model_outs();
    return pack(m_state, m_score, m_lives, m_tl, (m_state == S_PLAY) ? 1 : 0);
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_score = 0; m_lives = 0; m_tl = 0;
  endtask

  // Game rules as plain arithmetic on the observable quantities.
  task automatic model_step(input bit st, input bit pa, input bit tk, input bit ht, input bit ms);
    int s2, l2, t2;
    case (m_state)
      S_IDLE: if (st) begin
        m_state = S_READY; m_score = 0; m_lives = LI; m_tl = RT;
      end
      S_READY: if (tk) begin
        if (m_tl == 1) begin m_state = S_PLAY; m_tl = GT; end
        else m_tl = m_tl - 1;
      end
      S_PLAY: begin
        s2 = ht ? ((m_score < 255) ? m_score + 1 : 255) : m_score;
        l2 = ms ? m_lives - 1 : m_lives;
        t2 = tk ? m_tl - 1 : m_tl;
        if (ht && s2 == WS)          m_state = S_CLEAR;
        else if (l2 == 0 || t2 == 0) m_state = S_OVER;
        else if (PAUSE_EN && pa)     m_state = S_PAUSE;
        m_score = s2; m_lives = l2; m_tl = t2;
      end
      S_PAUSE: if (pa) m_state = S_PLAY;
      S_OVER, S_CLEAR: if (st) m_state = S_IDLE;
      default: m_state = S_IDLE;
    endcase
  endtask

  // Present inputs for one clock edge, then sample 1 time unit after it.
  task automatic cyc(input bit st, input bit pa, input bit tk, input bit ht, input bit ms);
    start = st; pause = pa; tick = tk; hit = ht; miss = ms;
    @(posedge clk);
    #1;
    start = 0; pause = 0; tick = 0; hit = 0; miss = 0;
    model_step(st, pa, tk, ht, ms);
  endtask

  task automatic enter_play();
    cyc(1, 0, 0, 0, 0);
    repeat (RT) cyc(0, 0, 1, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1; start = 0; pause = 0; tick = 0; hit = 0; miss = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    if (outs() !== pack(0, 0, 0, 0, 0)) $display("FAIL reset_outputs got %s want %s", fmt(outs()), fmt(pack(0, 0, 0, 0, 0)));
    else passes++;
    checks++;
    rst = 0;
    cyc(0, 1, 1, 1, 1);
    if (outs() !== pack(0, 0, 0, 0, 0)) $display("FAIL idle_ignores got %s want %s", fmt(outs()), fmt(pack(0, 0, 0, 0, 0)));
    else passes++;
    checks++;
  endtask

  task automatic test_ready_to_play();
    cyc(1, 0, 0, 0, 0);
    if (outs() !== pack(1, 0, 3, 3, 0)) $display("FAIL start_ready got %s want %s", fmt(outs()), fmt(pack(1, 0, 3, 3, 0)));
    else passes++;
    checks++;
    cyc(0, 0, 0, 1, 1);
    if (outs() !== pack(1, 0, 3, 3, 0)) $display("FAIL ready_ignores got %s want %s", fmt(outs()), fmt(pack(1, 0, 3, 3, 0)));
    else passes++;
    checks++;
    for (int i = 1; i <= 3; i++) begin
      cyc(i == 3, 0, 1, 0, 0);
      if (i < 3 && outs() !== pack(1, 0, 3, 3 - i, 0)) $display("FAIL ready_tick%0d got %s want %s", i, fmt(outs()), fmt(pack(1, 0, 3, 3 - i, 0)));
      else if (i == 3 && outs() !== pack(2, 0, 3, 60, 1)) $display("FAIL ready_to_play got %s want %s", fmt(outs()), fmt(pack(2, 0, 3, 60, 1)));
      else passes++;
      checks++;
    end
    cyc(1, 0, 0, 0, 0);
    if (outs() !== pack(2, 0, 3, 60, 1)) $display("FAIL play_ignores_start got %s want %s", fmt(outs()), fmt(pack(2, 0, 3, 60, 1)));
    else passes++;
    checks++;
  endtask

  task automatic test_win();
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 0, 0, 1, 0);
      if (outs() !== pack((i == 20) ? 5 : 2, i, 3, 60, (i < 20) ? 1 : 0)) begin
        $display("FAIL win_hit%0d got %s want %s", i, fmt(outs()), fmt(pack((i == 20) ? 5 : 2, i, 3, 60, (i < 20) ? 1 : 0)));
      end else passes++;
      checks++;
    end
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 0, 1, 0);
    if (outs() !== pack(5, 20, 3, 60, 0)) $display("FAIL clear_sticky got %s want %s", fmt(outs()), fmt(pack(5, 20, 3, 60, 0)));
    else passes++;
    checks++;
    cyc(1, 0, 0, 0, 0);
    if (outs() !== pack(0, 20, 3, 60, 0)) $display("FAIL clear_to_idle got %s want %s", fmt(outs()), fmt(pack(0, 20, 3, 60, 0)));
    else passes++;
    checks++;
  endtask

  task automatic test_lives();
    enter_play();
    cyc(0, 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      if (outs() !== pack((i == 3) ? 3 : 2, 0, 3 - i, 59, (i < 3) ? 1 : 0)) begin
        $display("FAIL miss%0d got %s want %s", i, fmt(outs()), fmt(pack((i == 3) ? 3 : 2, 0, 3 - i, 59, (i < 3) ? 1 : 0)));
      end else passes++;
      checks++;
    end
    cyc(0, 0, 1, 1, 0);
    if (outs() !== pack(3, 0, 0, 59, 0)) $display("FAIL over_sticky got %s want %s", fmt(outs()), fmt(pack(3, 0, 0, 59, 0)));
    else passes++;
    checks++;
    cyc(1, 0, 0, 0, 0);
    if (state !== 3'd0) $display("FAIL over_to_idle got state=%0d want 0", state);
    else passes++;
    checks++;
  endtask

  task automatic test_corners();
    enter_play();
    cyc(0, 0, 0, 1, 1);
    if (outs() !== pack(2, 1, 2, 60, 1)) $display("FAIL hit_and_miss got %s want %s", fmt(outs()), fmt(pack(2, 1, 2, 60, 1)));
    else passes++;
    checks++;
    repeat (18) cyc(0, 0, 0, 1, 0);
    repeat (59) cyc(0, 0, 1, 0, 0);
    if (outs() !== pack(2, 19, 2, 1, 1)) $display("FAIL pre_corner got %s want %s", fmt(outs()), fmt(pack(2, 19, 2, 1, 1)));
    else passes++;
    checks++;
    cyc(0, 0, 1, 1, 0);
    if (outs() !== pack(5, 20, 2, 0, 0)) $display("FAIL clear_beats_timeout got %s want %s", fmt(outs()), fmt(pack(5, 20, 2, 0, 0)));
    else passes++;
    checks++;
    cyc(1, 0, 0, 0, 0);
    enter_play();
    repeat (60) cyc(0, 0, 1, 0, 0);
    if (outs() !== pack(3, 0, 3, 0, 0)) $display("FAIL timeout_over got %s want %s", fmt(outs()), fmt(pack(3, 0, 3, 0, 0)));
    else passes++;
    checks++;
    cyc(1, 0, 0, 0, 0);
  endtask

  task automatic test_pause();
    enter_play();
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
`ifdef GAME_PAUSE_EN
    cyc(0, 1, 0, 0, 0);
    if (outs() !== pack(4, 2, 3, 59, 0)) $display("FAIL pause_enter got %s want %s", fmt(outs()), fmt(pack(4, 2, 3, 59, 0)));
    else passes++;
    checks++;
    repeat (5) cyc(0, 0, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 1);
    if (outs() !== pack(4, 2, 3, 59, 0)) $display("FAIL pause_frozen got %s want %s", fmt(outs()), fmt(pack(4, 2, 3, 59, 0)));
    else passes++;
    checks++;
    cyc(0, 1, 0, 0, 0);
    if (outs() !== pack(2, 2, 3, 59, 1)) $display("FAIL pause_resume got %s want %s", fmt(outs()), fmt(pack(2, 2, 3, 59, 1)));
    else passes++;
    checks++;
`else
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    if (outs() !== pack(2, 2, 3, 58, 1)) $display("FAIL pause_ignored got %s want %s", fmt(outs()), fmt(pack(2, 2, 3, 58, 1)));
    else passes++;
    checks++;
`endif
  endtask

  task automatic test_async_reset();
    if (state !== 3'd2) begin
      enter_play();
    end
    cyc(0, 0, 0, 1, 0);
    #3;
    rst = 1;
    #1;
    if (outs() !== pack(0, 0, 0, 0, 0)) $display("FAIL async_reset got %s want %s", fmt(outs()), fmt(pack(0, 0, 0, 0, 0)));
    else passes++;
    checks++;
    model_reset();
    @(negedge clk);
    rst = 0;
    cyc(1, 0, 0, 0, 0);
    if (outs() !== pack(1, 0, 3, 3, 0)) $display("FAIL first_edge_after_reset got %s want %s", fmt(outs()), fmt(pack(1, 0, 3, 3, 0)));
    else passes++;
    checks++;
  endtask

  task automatic test_random();
    bit st, pa, tk, ht, ms;
    for (int n = 0; n < 4000; n++) begin
      st = ($urandom_range(0, 11) == 0);
      pa = ($urandom_range(0, 15) == 0);
      tk = ($urandom_range(0, 3) == 0);
      ht = ($urandom_range(0, 2) == 0);
      ms = ($urandom_range(0, 8) == 0);
      cyc(st, pa, tk, ht, ms);
      if (outs() !== model_outs()) $display("FAIL random_cyc%0d got %s want %s", n, fmt(outs()), fmt(model_outs()));
      else passes++;
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_ready_to_play();
    test_win();
    test_lives();
    test_corners();
    test_pause();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
